// File: rtl/audio_sector_scheduler.sv
// Sector playback scheduler: queues sector addresses and codings, starts the audio
// decoder on the queue head whenever it is idle, and generates the 75 Hz sector tick.
module audio_sector_scheduler #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 400000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq,
  input  logic [12:0]              enq_addr,
  input  logic                     enq_external,
  input  logic [7:0]               enq_coding,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     dec_start,
  output logic [12:0]              dec_addr,
  output logic                     dec_use_external,
  output logic [7:0]               dec_coding,
  output logic                     dec_reset_filter,
  input  logic                     dec_idle,
  input  logic                     dec_disable_audiomap,
  output logic                     audio_tick,
  output logic                     playing,
  output logic                     sector_done,
  output logic [12:0]              sector_done_addr,
  output logic                     stopped,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

  state_t state, next_state;

  logic [12:0]   q_addr   [DEPTH];
  logic          q_ext    [DEPTH];
  logic [7:0]    q_coding [DEPTH];
  logic [AW-1:0] rd, wr;
  logic          stop_flag, flush_flag;
  logic [TW-1:0] tick_cnt;

  logic start_go, underrun_go, done_go;
  logic active, stop_now, end_now, clear_all, keep_head, push, pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A flush seen in IDLE wins over starting a new sector from the same queue.
  always_comb begin
    next_state  = state;
    start_go    = 1'b0;
    underrun_go = 1'b0;
    done_go     = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (count != '0 && dec_idle) begin
            start_go   = 1'b1;
            next_state = LAUNCH;
          end else if (count == '0 && playing) begin
            underrun_go = 1'b1;
          end
        end
      end
      LAUNCH: if (!dec_idle) next_state = BUSY;
      BUSY: begin
        if (dec_idle) begin
          done_go    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign active    = (state != IDLE);
  assign stop_now  = stop_flag | (active & dec_disable_audiomap);
  assign end_now   = stop_now | flush_flag | flush;
  // Completing with a stop (or a same-cycle flush) empties everything, in-flight head included.
  assign clear_all = (flush & ~active) | (done_go & (stop_now | flush));
  assign keep_head = flush & active & ~done_go;
  assign push      = enq & ~flush & ~clear_all & (~full | done_go);
  assign pop       = done_go & ~clear_all;
  assign full      = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr]   <= enq_addr;
      q_ext[wr]    <= enq_external;
      q_coding[wr] <= enq_coding;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (clear_all) begin
      rd    <= wr;
      count <= '0;
    end else if (keep_head) begin
      wr    <= rd + AW'(1);
      count <= CW'(1);
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop)  rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_flag        <= 1'b0;
      flush_flag       <= 1'b0;
      playing          <= 1'b0;
      dec_start        <= 1'b0;
      dec_addr         <= '0;
      dec_use_external <= 1'b0;
      dec_coding       <= '0;
      dec_reset_filter <= 1'b0;
      sector_done      <= 1'b0;
      sector_done_addr <= '0;
      stopped          <= 1'b0;
      underrun         <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (done_go || !active) begin
        stop_flag  <= 1'b0;
        flush_flag <= 1'b0;
      end else begin
        if (dec_disable_audiomap) stop_flag  <= 1'b1;
        if (flush)                flush_flag <= 1'b1;
      end

      if (start_go)
        playing <= 1'b1;
      else if (underrun_go || (flush && !active) || (done_go && end_now))
        playing <= 1'b0;

      dec_start <= start_go;
      if (start_go) begin
        dec_addr         <= q_addr[rd];
        dec_use_external <= q_ext[rd];
        dec_coding       <= q_coding[rd];
        dec_reset_filter <= ~playing;
      end

      sector_done <= done_go;
      if (done_go) sector_done_addr <= dec_addr;
      stopped  <= done_go & stop_now;
      underrun <= underrun_go;
      overflow <= enq & ~flush & full & ~done_go;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            tick_cnt <= '0;
    else if (tick_cnt == TW'(TICK_DIV - 1))  tick_cnt <= '0;
    else                                     tick_cnt <= tick_cnt + TW'(1);
  end

  assign audio_tick = (tick_cnt == TW'(TICK_DIV - 1));

endmodule

// File: tb/tb_audio_sector_scheduler.sv
// Directed bench for audio_sector_scheduler with a simple decoder model that
// stays busy for a fixed number of cycles after each start pulse.
module tb_audio_sector_scheduler;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 10;
  localparam int BUSY_LEN = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq = 1'b0;
  logic [12:0] enq_addr = '0;
  logic        enq_external = 1'b0;
  logic [7:0]  enq_coding = '0;
  logic        flush = 1'b0;
  logic        full;
  logic [2:0]  count;
  logic        overflow, dec_start;
  logic [12:0] dec_addr;
  logic        dec_use_external;
  logic [7:0]  dec_coding;
  logic        dec_reset_filter, dec_idle;
  logic        dec_disable_audiomap = 1'b0;
  logic        audio_tick, playing, sector_done;
  logic [12:0] sector_done_addr;
  logic        stopped, underrun;

  logic        model_idle;
  int          busy_cnt;
  logic        dec_block = 1'b0;
  logic [46:0] all_outs;

  int checks = 0;
  int fails  = 0;

  logic [12:0] b2b_addr [3] = '{13'h0A00, 13'h0F00, 13'h1400};
  logic        b2b_ext  [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0]  b2b_cod  [3] = '{8'h00, 8'h15, 8'h00};

  always #5 clk = ~clk;

  audio_sector_scheduler #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .enq(enq), .enq_addr(enq_addr),
    .enq_external(enq_external), .enq_coding(enq_coding), .flush(flush),
    .full(full), .count(count), .overflow(overflow), .dec_start(dec_start),
    .dec_addr(dec_addr), .dec_use_external(dec_use_external), .dec_coding(dec_coding),
    .dec_reset_filter(dec_reset_filter), .dec_idle(dec_idle),
    .dec_disable_audiomap(dec_disable_audiomap), .audio_tick(audio_tick),
    .playing(playing), .sector_done(sector_done), .sector_done_addr(sector_done_addr),
    .stopped(stopped), .underrun(underrun)
  );

  assign all_outs = {full, count, overflow, dec_start, dec_addr, dec_use_external, dec_coding,
                     dec_reset_filter, audio_tick, playing, sector_done, sector_done_addr,
                     stopped, underrun};

  // Decoder model: leaves idle the cycle after a start, returns after BUSY_LEN cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_idle <= 1'b1;
      busy_cnt   <= 0;
    end else if (dec_start) begin
      model_idle <= 1'b0;
      busy_cnt   <= BUSY_LEN;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt   <= 0;
      model_idle <= 1'b1;
    end
  end

  assign dec_idle = model_idle & ~dec_block;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    enq = 1'b0; flush = 1'b0; dec_disable_audiomap = 1'b0; dec_block = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_entry(input logic [12:0] a, input logic e, input logic [7:0] c);
    enq = 1'b1; enq_addr = a; enq_external = e; enq_coding = c;
    @(negedge clk);
    enq = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dec_start) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sector_done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (all_outs !== '0) begin fails++; $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs); end
    checks++;
    if (count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    push_entry(13'h0A00, 1'b0, 8'h00);
    checks++;
    if (count !== 3'd1 || dec_start !== 1'b0) begin
      fails++; $display("[TB] FAIL single_enq: count %0d start %b expected 1/0", count, dec_start);
    end
    @(negedge clk);
    checks++;
    if (dec_start !== 1'b1 || dec_addr !== 13'h0A00 || dec_reset_filter !== 1'b1 || playing !== 1'b1) begin
      fails++; $display("[TB] FAIL single_start: start %b addr %h rf %b play %b expected 1/0a00/1/1",
                        dec_start, dec_addr, dec_reset_filter, playing);
    end
    wait_done(seen);
    checks++;
    if (!seen || sector_done_addr !== 13'h0A00 || count !== 3'd0 || stopped !== 1'b0) begin
      fails++; $display("[TB] FAIL single_done: seen %b addr %h count %0d stopped %b expected 1/0a00/0/0",
                        seen, sector_done_addr, count, stopped);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || playing !== 1'b0) begin
      fails++; $display("[TB] FAIL single_underrun: underrun %b playing %b expected 1/0", underrun, playing);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin fails++; $display("[TB] FAIL single_underrun_pulse: got %b expected 0", underrun); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    do_reset();
    dec_block = 1'b1;
    for (int i = 0; i < 3; i++) push_entry(b2b_addr[i], b2b_ext[i], b2b_cod[i]);
    checks++;
    if (count !== 3'd3) begin fails++; $display("[TB] FAIL b2b_count_init: got %0d expected 3", count); end
    dec_block = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        wait_start(seen);
      end else begin
        @(negedge clk);
        seen = dec_start;
      end
      checks++;
      if (!seen || dec_addr !== b2b_addr[i] || dec_reset_filter !== (i == 0) ||
          dec_use_external !== b2b_ext[i] || dec_coding !== b2b_cod[i] || count !== 3'(3 - i)) begin
        fails++; $display("[TB] FAIL b2b_start%0d: seen %b addr %h rf %b ext %b cod %h count %0d expected addr %h rf %b ext %b cod %h count %0d",
                          i, seen, dec_addr, dec_reset_filter, dec_use_external, dec_coding, count,
                          b2b_addr[i], (i == 0), b2b_ext[i], b2b_cod[i], 3 - i);
      end
      wait_done(seen);
      checks++;
      if (!seen || sector_done_addr !== b2b_addr[i] || count !== 3'(2 - i)) begin
        fails++; $display("[TB] FAIL b2b_done%0d: seen %b addr %h count %0d expected addr %h count %0d",
                          i, seen, sector_done_addr, count, b2b_addr[i], 2 - i);
      end
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1 || dec_start !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_underrun: underrun %b start %b expected 1/0", underrun, dec_start);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    int ovf_total = 0;
    do_reset();
    push_entry(13'h0100, 1'b0, 8'h00);
    wait_start(seen);
    checks++;
    if (!seen) begin fails++; $display("[TB] FAIL ovf_start: no dec_start seen, expected one"); end
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      enq = 1'b1; enq_addr = 13'(13'h0100 + k); enq_external = 1'b0; enq_coding = 8'h00;
      @(negedge clk);
      if (overflow) ovf_total++;
      checks++;
      if (overflow !== (k == 4) || count !== 3'((k >= 3) ? 4 : k + 1)) begin
        fails++; $display("[TB] FAIL ovf_enq%0d: overflow %b count %0d expected %b/%0d",
                          k, overflow, count, (k == 4), (k >= 3) ? 4 : k + 1);
      end
    end
    enq = 1'b0;
    @(negedge clk);
    if (overflow) ovf_total++;
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || ovf_total != 1) begin
      fails++; $display("[TB] FAIL ovf_final: full %b count %0d pulses %0d expected 1/4/1", full, count, ovf_total);
    end
  endtask

  task automatic test_flush();
    bit seen;
    int starts = 0, unders = 0;
    do_reset();
    dec_block = 1'b1;
    for (int i = 0; i < 3; i++) push_entry(13'(13'h0200 + i), 1'b0, 8'h00);
    dec_block = 1'b0;
    wait_start(seen);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (!seen || count !== 3'd1 || playing !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_mid: started %b count %0d playing %b expected 1/1/1", seen, count, playing);
    end
    wait_done(seen);
    checks++;
    if (!seen || sector_done_addr !== 13'h0200 || count !== 3'd0 || playing !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_done: seen %b addr %h count %0d playing %b expected 1/0200/0/0",
                        seen, sector_done_addr, count, playing);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dec_start) starts++;
      if (underrun) unders++;
    end
    checks++;
    if (starts != 0 || unders != 0) begin
      fails++; $display("[TB] FAIL flush_quiet: starts %0d underruns %0d expected 0/0", starts, unders);
    end
    flush = 1'b1; enq = 1'b1; enq_addr = 13'h0300;
    @(negedge clk);
    flush = 1'b0; enq = 1'b0;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dec_start) starts++;
    end
    checks++;
    if (count !== 3'd0 || starts != 0) begin
      fails++; $display("[TB] FAIL flush_enq_priority: count %0d starts %0d expected 0/0", count, starts);
    end
  endtask

  task automatic test_stop();
    bit seen;
    int starts = 0, unders = 0;
    do_reset();
    dec_block = 1'b1;
    push_entry(13'h0400, 1'b1, 8'hFF);
    push_entry(13'h0500, 1'b0, 8'h00);
    dec_block = 1'b0;
    wait_start(seen);
    repeat (4) @(negedge clk);
    dec_disable_audiomap = 1'b1;
    @(negedge clk);
    dec_disable_audiomap = 1'b0;
    wait_done(seen);
    checks++;
    if (!seen || stopped !== 1'b1 || sector_done_addr !== 13'h0400 || count !== 3'd0 || playing !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_done: seen %b stopped %b addr %h count %0d playing %b expected 1/1/0400/0/0",
                        seen, stopped, sector_done_addr, count, playing);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dec_start) starts++;
      if (underrun) unders++;
    end
    checks++;
    if (starts != 0 || unders != 0 || stopped !== 1'b0) begin
      fails++; $display("[TB] FAIL stop_quiet: starts %0d underruns %0d stopped %b expected 0/0/0", starts, unders, stopped);
    end
  endtask

  // After release, the counter reads k after k edges; the tick shows at k = 9, 19, 29
  // (the 10th, 20th and 30th cycles counting the first post-reset cycle as cycle 1).
  task automatic test_tick();
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checks++;
      if (audio_tick !== ((k % 10) == 9)) begin
        fails++; $display("[TB] FAIL tick_k%0d: got %b expected %b", k, audio_tick, ((k % 10) == 9));
      end
    end
  endtask

  task automatic test_reset_busy();
    bit seen;
    int dones = 0;
    do_reset();
    push_entry(13'h1234, 1'b1, 8'hAB);
    wait_start(seen);
    repeat (6) @(negedge clk);
    checks++;
    if (!seen || dec_addr !== 13'h1234 || dec_coding !== 8'hAB || playing !== 1'b1) begin
      fails++; $display("[TB] FAIL rbusy_pre: seen %b addr %h coding %h playing %b expected 1/1234/ab/1",
                        seen, dec_addr, dec_coding, playing);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin fails++; $display("[TB] FAIL rbusy_async: got %h expected 0", all_outs); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sector_done) dones++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sector_done || dec_start) dones++;
    end
    checks++;
    if (dones != 0 || count !== 3'd0) begin
      fails++; $display("[TB] FAIL rbusy_after: events %0d count %0d expected 0/0", dones, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_stop();
    test_tick();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
